// File: rtl/mem_pkg.sv
// Shared definitions for the multicycle memory responder: FSM encodings,
// wait counter width and the word-address width derivation.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ACCESS = 3'd2,
    ST_RESP   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

  localparam int CNT_W = 4;

  // Number of word-index bits needed to address depth words.
  function automatic int word_addr_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port DEPTH_WORDS x 32 storage with synchronous write and a
// registered synchronous read; contents are never cleared by reset.
module mem_array #(
  parameter int DEPTH_WORDS = 64,
  parameter int AW          = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem_r [DEPTH_WORDS];
  logic [31:0] rdata_r;

  // Array write port, only active during an enabled store.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read data register; holds the last successful load and clears on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0;
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/mem_responder.sv
// Req/ready memory responder with configurable wait states in front of a
// single-port array; misaligned or out-of-range accesses finish with err.
module mem_responder
  import mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] adr,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        ready,
  output logic        err
);

  localparam int AW = word_addr_width(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);

  state_t           state_r;
  state_t           state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_s;
  logic [AW-1:0]    widx_r;
  logic             we_r;
  logic [31:0]      wd_r;
  logic             ready_r;
  logic             err_r;
  logic             bad_s;
  logic             take_s;
  logic             acc_en_s;

  // Reject misaligned addresses and any set bit above the word index,
  // so large addresses never alias onto low words.
  always_comb begin
    bad_s = (adr[1:0] != 2'b00) || (|adr[31:AW+2]);
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          if (bad_s) begin
            state_s = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_s = ST_ACCESS;
          end else begin
            state_s = ST_WAIT;
            cnt_s   = WAIT_INIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = ST_ACCESS;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_ACCESS: state_s = ST_RESP;
      ST_RESP:   state_s = ST_IDLE;
      ST_ERR:    state_s = ST_IDLE;
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Request fields are captured once so mid-access input changes are ignored.
  always_comb begin
    take_s   = (state_r == ST_IDLE) && req;
    acc_en_s = (state_r == ST_ACCESS);
  end

  // State, counter and registered handshake outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ready_r <= (state_s == ST_RESP) || (state_s == ST_ERR);
      err_r   <= (state_s == ST_ERR);
    end
  end

  // Request latches.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      widx_r <= '0;
      we_r   <= 1'b0;
      wd_r   <= 32'h0;
    end else if (take_s) begin
      widx_r <= adr[AW+1:2];
      we_r   <= we;
      wd_r   <= wd;
    end
  end

  mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_array (
    .clk   (clk),
    .rst_n (reset),
    .en    (acc_en_s),
    .we    (we_r),
    .addr  (widx_r),
    .wdata (wd_r),
    .rdata (rd)
  );

  assign ready = ready_r;
  assign err   = err_r;

endmodule

// File: doc/mem_responder.md
# mem_responder

Multicycle unified instruction/data memory that answers the processor's fetch, load and store accesses over a req/ready handshake with a configurable number of wait states. It sits between the multicycle datapath's address/write-data path and the memory array. The block takes the responder side of every memory access that the main control FSM initiates, replacing a zero-latency memory so the controller can be exercised against realistic stalls. Misaligned or out-of-range accesses complete with an error flag instead of touching storage.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words; a power of two, 4..4096.
- WAIT_STATES, 2: extra cycles inserted before the array access; 0..15.

- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserting low resets immediately; release synchronous to clk by the system).
- req  in  1  access request; requester holds req/we/adr/wd stable until ready.
- we  in  1  1 = store word, 0 = load/fetch word.
- adr  in  32  byte address.
- wd  in  32  store data.
- rd  out  32  load data, registered; holds last successful read value.
- ready  out  1  one-cycle completion pulse.
- err  out  1  asserted together with ready when the access was rejected.

## Operation
- States: IDLE, WAIT, ACCESS, RESP, ERR.
- IDLE, req=0: stay.
- IDLE, req=1: latch adr, we and wd.
  - If adr[1:0]≠0 or adr[31:2] ≥ DEPTH_WORDS → ERR.
  - Else if WAIT_STATES=0 → ACCESS.
  - Else → WAIT with cnt=WAIT_STATES.
- WAIT: cnt decrements each cycle; leave for ACCESS on the edge where cnt=1. WAIT therefore lasts exactly WAIT_STATES cycles.
- ACCESS: one cycle.
  - Store: the array writes the latched wd at word adr[31:2] on this edge.
  - Load: the array word is captured into rd on this edge.
  - Next state → RESP.
- RESP: ready=1, err=0 → IDLE.
- ERR: ready=1, err=1; no array write and rd unchanged → IDLE.
- Latched request fields, not live inputs, are used after IDLE, so input changes mid-access have no effect.
- Address width rule: the word index is adr[31:2]. Bits beyond log2(DEPTH_WORDS)+2 must be zero or the access is out of range. Wrap-around aliasing is forbidden.
- Memory contents are not cleared by reset. Array contents are undefined until written (the bench preloads them through hierarchical access).

## Timing
- Reset values: ready=0, err=0, rd=32'h0, state=IDLE, cnt=0.
- Latency: req first seen high in IDLE at cycle 0 → ready high in cycle 2+WAIT_STATES for a valid access, and in cycle 1 for an error.
  - WAIT_STATES=2 gives ready in cycle 4.
  - WAIT_STATES=0 gives ready in cycle 2.
- rd is valid in the ready cycle and stays stable until the next successful load completes.
- A store is visible to a load that starts in or after the RESP cycle of that store.
- ready and err are each high for exactly one cycle per access.
- The cycle after RESP/ERR is IDLE. If req is still high there, it is a new request. The requester must drop req in the cycle after ready unless it issues back-to-back accesses.
- Reset mid-operation: the state returns to IDLE immediately.
  - A store whose ACCESS edge has not occurred is dropped.
  - A load in flight produces no ready.
  - rd is cleared to 0.

## Structure
- Shared package mem_pkg holds:
  - state encodings: IDLE=0, WAIT=1, ACCESS=2, RESP=3, ERR=4, in a 3-bit state field;
  - the 4-bit wait counter width;
  - the word-address width derivation constant.
- One sub-module, mem_array: DEPTH_WORDS×32 storage with synchronous write, synchronous read and a single port. It is driven only in the ACCESS state.
- The top level contains the handshake FSM, the wait counter, the request latches and the error check.

## Test plan
- Reset with WAIT_STATES=2: hold reset low, check ready=0, err=0, rd=0. Release it, with req=0 for 5 cycles → ready stays 0.
- Store then load, WAIT_STATES=2: store 32'hDEADBEEF to adr 32'h10. Required: ready in cycle 4 with err=0. Then load adr 32'h10 → ready in cycle 4, rd=32'hDEADBEEF.
- WAIT_STATES=0: back-to-back load requests with req held high. Required: ready pulses every 3 cycles, each at cycle 2 of its request, with rd updating accordingly.
- Error cases with DEPTH_WORDS=64:
  - Store to adr 32'h6 → ready=1 and err=1 in cycle 1.
  - Store to adr 32'h100 → same response.
  - In both cases a subsequent load of words 1 and 0 shows the old contents unchanged.
- Input change mid-access: change adr and wd during WAIT. Required: the write lands at the originally latched address with the originally latched data.
- Reset during WAIT of a store to adr 32'h20: the word keeps its prior value, no ready pulse occurs, and rd=0 after reset.
